// File: rtl/entry_sequencer.sv
// Button-driven code entry sequencer: collects WIDTH bits, hands them to an
// algorithm datapath over a valid/ready request and displays the result.
// Optional macro ENTRY_SEQUENCER_SYNC_EN adds two-flop input synchronizers.
//
// state | meaning
// ------+--------------------------------------------------------------
// ENTRY | collecting bits; led shows the entered value
// SEND  | req_valid high, waiting for req_ready
// WAIT  | request accepted, waiting for resp_valid
// SHOW  | led shows the result word until clear
module entry_sequencer #(
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enter0,
    input  logic             enter1,
    input  logic             confirm,
    input  logic             clear,
    input  logic             algorithm_select_mode,
    output logic             req_valid,
    input  logic             req_ready,
    output logic [WIDTH-1:0] req_data,
    output logic             req_alg,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_data,
    output logic [WIDTH-1:0] led,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        SEND  = 2'd1,
        WAIT  = 2'd2,
        SHOW  = 2'd3
    } state_t;

    logic [4:0] raw;
    logic [4:0] btn;
    logic [3:0] hist;
    logic [3:0] press;
    logic [1:0] arm_cnt;
    logic       armed;

    assign raw = {algorithm_select_mode, clear, confirm, enter1, enter0};

`ifdef ENTRY_SEQUENCER_SYNC_EN
    localparam logic [1:0] ARM_LOAD = 2'd3;
    logic [4:0] sync1;
    logic [4:0] sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    assign btn = sync2;
`else
    localparam logic [1:0] ARM_LOAD = 2'd1;
    assign btn = raw;
`endif

    // Presses are masked until a button held through reset release has
    // propagated into the edge-detector history.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arm_cnt <= ARM_LOAD;
            hist    <= '0;
        end else begin
            if (arm_cnt != 2'd0) begin
                arm_cnt <= arm_cnt - 2'd1;
            end
            hist <= btn[3:0];
        end
    end

    assign armed = (arm_cnt == 2'd0);
    assign press = armed ? (btn[3:0] & ~hist) : 4'b0000;

    logic p_e0;
    logic p_e1;
    logic p_conf;
    logic p_clr;
    logic alg_in;

    assign p_e0   = press[0];
    assign p_e1   = press[1];
    assign p_conf = press[2];
    assign p_clr  = press[3];
    assign alg_in = btn[4];

    state_t           state, state_n;
    logic [WIDTH-1:0] value, value_n;
    logic [CW-1:0]    count, count_n;
    logic [WIDTH-1:0] result, result_n;
    logic             alg_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ENTRY;
            value  <= '0;
            count  <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            value  <= value_n;
            count  <= count_n;
            result <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        value_n  = value;
        count_n  = count;
        result_n = result;
        alg_n    = req_alg;
        case (state)
            ENTRY: begin
                if (p_clr) begin
                    value_n = '0;
                    count_n = '0;
                end else begin
                    if ((p_e0 ^ p_e1) && (count < FULL)) begin
                        value_n = {value[WIDTH-2:0], p_e1};
                        count_n = count + CW'(1);
                    end
                    if (p_conf && (count == FULL)) begin
                        alg_n   = alg_in;
                        state_n = SEND;
                    end
                end
            end
            SEND: begin
                if (req_ready) begin
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    result_n = resp_data;
                    state_n  = SHOW;
                end
            end
            SHOW: begin
                if (p_clr) begin
                    value_n = '0;
                    count_n = '0;
                    state_n = ENTRY;
                end
            end
            default: state_n = ENTRY;
        endcase
    end

    // Outputs are registered from next-state values so they track the state
    // register without any combinational path from the inputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_valid <= 1'b0;
            busy      <= 1'b0;
            req_alg   <= 1'b0;
            req_data  <= '0;
            led       <= '0;
        end else begin
            req_valid <= (state_n == SEND);
            busy      <= (state_n == SEND) || (state_n == WAIT);
            req_alg   <= alg_n;
            req_data  <= value_n;
            led       <= (state_n == SHOW) ? result_n : value_n;
        end
    end

endmodule
